// File: rtl/obi_mem_arbiter_pkg.sv
// obi_arb_pkg: shared types and constants for the fetch/data memory arbiter
package obi_arb_pkg;

    typedef enum logic [1:0] {
        ARB,
        HOLD_I,
        HOLD_D
    } arb_state_e;

    typedef enum logic {
        MST_INSTR = 1'b0,
        MST_DATA  = 1'b1
    } mst_id_e;

    // Wide enough for data widths up to 512 bits; users slice the low bits.
    localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/obi_mem_arbiter_id_fifo.sv
// id_fifo: small FIFO remembering which master owns each outstanding transaction
module id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap explicitly so any depth works; count tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (do_pop) rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: round-robin sharing of one memory port between fetch and data masters
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e    state;
    mst_id_e       rr_ptr;
    mst_id_e       sel;
    mst_id_e       head;
    logic          req_any;
    logic          is_data;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          head_bit;
    logic [CW-1:0] count;

    // Winner: locked master while holding, otherwise round-robin among requesters.
    always_comb begin
        sel     = (state == HOLD_I) ? MST_INSTR :
                  (state == HOLD_D) ? MST_DATA :
                  (instr_req_i && data_req_i) ? rr_ptr :
                  data_req_i ? MST_DATA : MST_INSTR;
        req_any = (state == HOLD_I) ? instr_req_i :
                  (state == HOLD_D) ? data_req_i :
                  (instr_req_i | data_req_i);
    end

    assign is_data    = sel == MST_DATA;
    assign mem_req_o  = req_any & ~full;
    assign push       = mem_req_o & mem_gnt_i;
    assign pop        = mem_rvalid_i & ~empty;
    assign head       = mst_id_e'(head_bit);

    assign instr_gnt_o = push & ~is_data;
    assign data_gnt_o  = push & is_data;

    // Payload is zeroed when idle so an unused port shows no stray activity.
    assign mem_we_o    = mem_req_o & is_data & data_we_i;
    assign mem_be_o    = !mem_req_o ? '0 : is_data ? data_be_i : BE_ALL[BW-1:0];
    assign mem_addr_o  = !mem_req_o ? '0 : is_data ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = (mem_req_o && is_data) ? data_wdata_i : '0;

    assign instr_rvalid_o = pop & (head == MST_INSTR);
    assign data_rvalid_o  = pop & (head == MST_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign busy_o         = count != '0;

    id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wdata  (is_data),
        .rdata  (head_bit),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // Lock onto a stalled winner, release and rotate priority on handshake, flag orphan responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ARB;
            rr_ptr <= MST_INSTR;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                state  <= ARB;
                rr_ptr <= is_data ? MST_INSTR : MST_DATA;
            end else if (mem_req_o && state == ARB) begin
                state <= is_data ? HOLD_D : HOLD_I;
            end
            if (mem_rvalid_i && empty) err_o <= 1'b1;
        end
    end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one single-port memory (req/gnt/rvalid protocol) between the core's instruction-fetch port and data port.
- Arbitrates round-robin and holds the selected request stable until it is granted.
- Tracks outstanding transactions in an ID FIFO and routes each rvalid back to the master that issued it.
- Sits between the RI5CY core memory interfaces and the shared TB/FPGA memory model.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (power of two, >=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_gnt_o  out  1  fetch request accepted.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetch read data.
- data_req_i  in  1  data request.
- data_we_i  in  1  1 = write.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid (reads and writes).
- data_rdata_o  out  DATA_WIDTH  data read data.
- mem_req_o  out  1  shared memory request.
- mem_we_o  out  1  shared write enable.
- mem_be_o  out  DATA_WIDTH/8  shared byte enables.
- mem_addr_o  out  ADDR_WIDTH  shared address.
- mem_wdata_o  out  DATA_WIDTH  shared write data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response valid, strictly in order.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- busy_o  out  1  at least one transaction outstanding.
- err_o  out  1  sticky protocol error (rvalid with empty FIFO).

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: FSM=ARB, FIFO empty, rr_ptr=INSTR, err_o=0.
  - With no inputs asserted, all outputs are 0 after reset.
- FSM states:
  - ARB: selects a winner combinationally from the current requests.
  - HOLD_I / HOLD_D: the selection is locked to instr or data.
- ARB winner selection:
  - Both requesting: winner = rr_ptr.
  - One requesting: that one.
  - None: mem_req_o=0.
- ARB transitions:
  - Winner driven with mem_gnt_i=1 and FIFO not full: handshake. Stay in ARB, push winner ID, rr_ptr := other master.
  - Winner driven with mem_gnt_i=0: go to HOLD_<winner> next cycle.
- HOLD_x:
  - mem_* outputs are driven from master x only; the other master is ignored.
  - On handshake: push x, rr_ptr := other, go to ARB.
  - Masters keep req and payload stable until gnt, so no payload register is needed.
- Full FIFO: mem_req_o forced 0 and no gnt is issued; FSM state is unchanged.
  - A pop in the same cycle does not unblock; the grant occurs the following cycle.
- Master gnt: x_gnt_o = mem_gnt_i & mem_req_o & (selected == x). Combinational, zero added latency.
- Instruction winner payload: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0, mem_addr_o=instr_addr_i.
- Data winner payload: data_* fields passed straight through.
- Response routing:
  - On mem_rvalid_i, pop the FIFO head ID and assert that master's rvalid in the same cycle (combinational).
  - Both rdata outputs = mem_rdata_i (broadcast); only the owner's rvalid is high.
- Error case: mem_rvalid_i while the FIFO is empty means no pop, no rvalid out, and err_o := 1 until reset.
- Simultaneous push and pop (FIFO not full): both take effect; count unchanged.
- busy_o = (count != 0).
- Reset mid-transaction flushes the FIFO; late rvalids then set err_o.

Decomposition:
- Package obi_arb_pkg:
  - typedef enum logic [1:0] {ARB, HOLD_I, HOLD_D} arb_state_e.
  - typedef enum logic {MST_INSTR=0, MST_DATA=1} mst_id_e.
  - localparam BE_ALL.
- Sub-module id_fifo (width 1, depth MAX_OUTSTANDING):
  - Ports push, pop, wdata, rdata, full, empty, count.
  - Same clock and reset as the parent.

Test Plan:
- Single instr fetch: instr_req_i=1, addr 0x0000000A, mem_gnt_i=1 → mem_addr_o=0x0A, mem_be_o=4'hF, instr_gnt_o=1. Next cycle mem_rvalid_i=1, rdata 0x002180B3 → instr_rvalid_o=1, instr_rdata_o=0x002180B3, data_rvalid_o=0.
- Contention round-robin: both req held, mem_gnt_i=1 every cycle, rvalid 1 cycle later → grants alternate I,D,I,D starting with instr after reset; responses route I,D,I,D.
- Stall hold: data wins with mem_gnt_i=0 for 3 cycles while instr_req_i=1 → mem_addr_o stays data_addr_i (0x1000) all 3 cycles, FSM=HOLD_D. gnt on cycle 4 → data_gnt_o=1, and instr wins next.
- FIFO full: MAX_OUTSTANDING=2, two grants and no rvalid → third request sees mem_req_o=0 and busy_o=1. One rvalid pops → grant one cycle later.
- Write passthrough: data_we_i=1, be 4'b0011, wdata 0xDEADBEEF, addr 0x20 → mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF. Later rvalid → data_rvalid_o=1.
- Protocol error and reset: mem_rvalid_i=1 with FIFO empty → err_o=1 and stays high. Assert rst_ni=0 mid-transaction → err_o=0, busy_o=0 asynchronously.
